// File: rtl/arrhythmia_frame_sequencer_pkg.sv
// Shared defaults and FSM encoding for the arrhythmia classifier front/back-end sequencer.
package arrhythmia_frame_sequencer_pkg;

    localparam int BITSIZE_DEF      = 16;
    localparam int N_FEAT_DEF       = 10;
    localparam int PIPE_LATENCY_DEF = 24;
    localparam int CNT_W_DEF        = 16;

    // Encoding 2'd3 is unreachable and is treated as FILL by the sequencer.
    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/arrhythmia_frame_sequencer_sm_gt.sv
// Sign-magnitude greater-than: a_gt_b = (a > b), with +0 and -0 treated as equal.
module arrhythmia_sm_gt #(
    parameter int BITSIZE = 16
) (
    input  logic [BITSIZE-1:0] a,
    input  logic [BITSIZE-1:0] b,
    output logic               a_gt_b
);

    localparam int M = BITSIZE - 1;

    logic [M-1:0] mag_a, mag_b;
    logic         neg_a, neg_b;

    assign mag_a = a[M-1:0];
    assign mag_b = b[M-1:0];
    // A zero magnitude counts as non-negative, so -0 compares equal to +0.
    assign neg_a = a[M] && (mag_a != '0);
    assign neg_b = b[M] && (mag_b != '0);

    always_comb begin
        a_gt_b = 1'b0;
        case ({neg_a, neg_b})
            2'b01:   a_gt_b = 1'b1;
            2'b10:   a_gt_b = 1'b0;
            2'b00:   a_gt_b = (mag_a > mag_b);
            default: a_gt_b = (mag_a < mag_b);
        endcase
    end

endmodule

// File: rtl/arrhythmia_frame_sequencer.sv
// Packs serial samples into the classifier input vector, waits out the pipeline latency,
// captures y and offers the class decision on a valid/ready handshake.
module arrhythmia_frame_sequencer
    import arrhythmia_frame_sequencer_pkg::*;
#(
    parameter int BITSIZE      = BITSIZE_DEF,
    parameter int N_FEAT       = N_FEAT_DEF,
    parameter int PIPE_LATENCY = PIPE_LATENCY_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [BITSIZE-1:0]        s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [BITSIZE*N_FEAT-1:0] x_out,
    input  logic [2*BITSIZE-1:0]      y_in,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [2*BITSIZE-1:0]      res_y,
    output logic                      res_class,
    output logic [CNT_W-1:0]          frame_cnt
);

    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int LAT_W = $clog2(PIPE_LATENCY + 1);

    state_t                           state, next_state;
    logic [IDX_W-1:0]                 idx;
    logic [LAT_W-1:0]                 lat_cnt;
    logic [N_FEAT-1:0][BITSIZE-1:0]   shadow, frame_next;
    logic                             accept, last, capture, consume, y_gt;

    arrhythmia_sm_gt #(.BITSIZE(BITSIZE)) u_sm_gt (
        .a      (y_in[2*BITSIZE-1:BITSIZE]),
        .b      (y_in[BITSIZE-1:0]),
        .a_gt_b (y_gt)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_FILL;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        accept     = 1'b0;
        last       = 1'b0;
        capture    = 1'b0;
        consume    = 1'b0;
        case (state)
            ST_WAIT: begin
                if (lat_cnt == LAT_W'(PIPE_LATENCY)) begin
                    capture    = 1'b1;
                    next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    consume    = 1'b1;
                    next_state = ST_FILL;
                end
            end
            default: begin
                next_state = ST_FILL;
                s_ready    = 1'b1;
                accept     = s_valid;
                last       = s_valid && (idx == IDX_W'(N_FEAT - 1));
                if (last) next_state = ST_WAIT;
            end
        endcase
    end

    // The last sample goes straight to x_out so the whole frame switches on one edge.
    always_comb begin
        frame_next           = shadow;
        frame_next[N_FEAT-1] = s_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            lat_cnt   <= '0;
            shadow    <= '0;
            x_out     <= '0;
            res_y     <= '0;
            res_class <= 1'b0;
            res_valid <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (accept) begin
                shadow[idx] <= s_data;
                idx         <= last ? '0 : idx + 1'b1;
            end
            if (last) begin
                x_out   <= frame_next;
                lat_cnt <= LAT_W'(1);
            end else if (state == ST_WAIT) begin
                lat_cnt <= lat_cnt + 1'b1;
            end
            if (capture) begin
                res_y     <= y_in;
                res_class <= y_gt;
                res_valid <= 1'b1;
            end
            if (consume) begin
                res_valid <= 1'b0;
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arrhythmia_frame_sequencer.sv
// Directed and randomized frames checked against a value-level model of framing, latency and class rule.
module tb_arrhythmia_frame_sequencer;

    localparam int B  = 16;
    localparam int N  = 10;
    localparam int PL = 24;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [B-1:0]     s_data;
    logic             s_valid;
    logic             s_ready;
    logic [B*N-1:0]   x_out;
    logic [2*B-1:0]   y_in;
    logic             res_valid;
    logic             res_ready;
    logic [2*B-1:0]   res_y;
    logic             res_class;
    logic [CW-1:0]    frame_cnt;

    int               total = 0;
    int               bad = 0;
    int               exp_cnt = 0;
    logic [B-1:0]     smp [N];
    logic [B*N-1:0]   exp_x = '0;

    arrhythmia_frame_sequencer #(
        .BITSIZE(B), .N_FEAT(N), .PIPE_LATENCY(PL), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .x_out(x_out), .y_in(y_in), .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_class(res_class), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [B*N-1:0] obs, input logic [B*N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Signed integer view of a sign-magnitude word; -0 naturally equals +0.
    function automatic bit model_gt(input logic [B-1:0] a, input logic [B-1:0] b);
        int va, vb;
        va = int'(a[B-2:0]);
        vb = int'(b[B-2:0]);
        if (a[B-1]) va = -va;
        if (b[B-1]) vb = -vb;
        return va > vb;
    endfunction

    task automatic feed(input bit gap);
        for (int i = 0; i < N; i++) begin
            s_valid = 1'b1;
            s_data  = smp[i];
            if (i == N - 1) begin
                check("x_held_in_fill", x_out, exp_x);
                check("s_ready_fill", s_ready, 1);
            end
            tick;
            if (gap && i < N - 1) begin
                s_valid = 1'b0;
                s_data  = B'($urandom);
                tick;
            end
        end
        s_valid = 1'b0;
        for (int i = 0; i < N; i++) exp_x[i*B +: B] = smp[i];
        check("x_frame", x_out, exp_x);
        check("s_ready_wait", s_ready, 0);
    endtask

    task automatic result(input logic [2*B-1:0] y, input int hold);
        bit cls;
        cls = model_gt(y[2*B-1:B], y[B-1:0]);
        y_in = y;
        res_ready = 1'b1;
        for (int k = 1; k < PL; k++) tick;
        check("res_valid_early", res_valid, 0);
        res_ready = 1'b0;
        tick;
        check("res_valid", res_valid, 1);
        check("res_y", res_y, y);
        check("res_class", res_class, cls);
        check("cnt_at_capture", frame_cnt, exp_cnt);
        y_in = $urandom;
        for (int k = 0; k < hold; k++) begin
            s_valid = 1'b1;
            s_data  = B'($urandom);
            tick;
            check("hold_outputs", {res_valid, res_class, res_y, s_ready}, {1'b1, cls, y, 1'b0});
            check("hold_x", x_out, exp_x);
        end
        res_ready = 1'b1;
        s_valid   = 1'b1;
        s_data    = 16'hDEAD;
        tick;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        res_ready = 1'b0;
        s_valid   = 1'b0;
        check("res_valid_cleared", res_valid, 0);
        check("frame_cnt", frame_cnt, exp_cnt);
        check("s_ready_after_accept", s_ready, 1);
    endtask

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_data = '0; y_in = '0; res_ready = 1'b0;
        tick; tick;
        check("rst_x", x_out, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_res_y", res_y, 0);
        check("rst_res_class", res_class, 0);
        reset = 1'b0;
        tick;
        check("rst_s_ready", s_ready, 1);

        for (int i = 0; i < N; i++) smp[i] = B'(i + 1);
        feed(1'b0);
        result(32'h0300_0100, 50);

        for (int i = 0; i < N; i++) smp[i] = B'($urandom);
        feed(1'b1);
        result(32'h0100_0100, 2);

        for (int i = 0; i < N; i++) smp[i] = B'($urandom);
        feed(1'b0);
        result(32'h8000_0000, 0);

        for (int i = 0; i < N; i++) smp[i] = B'($urandom);
        feed(1'b1);
        result(32'h8001_8005, 1);

        // Partial frame, then reset discards it and the frame counter.
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = B'($urandom);
            tick;
        end
        s_valid = 1'b0;
        reset   = 1'b1;
        tick;
        reset   = 1'b0;
        exp_cnt = 0;
        exp_x   = '0;
        check("midrst_x", x_out, 0);
        check("midrst_s_ready", s_ready, 1);
        check("midrst_cnt", frame_cnt, 0);
        check("midrst_res_valid", res_valid, 0);

        for (int f = 0; f < (1 << CW); f++) begin
            for (int i = 0; i < N; i++) smp[i] = B'($urandom);
            feed(f[0]);
            result($urandom, int'($urandom_range(0, 3)));
        end
        check("cnt_wrapped", frame_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
